// File: rtl/rtc_div_pkg.sv
// Shared constants and helpers for the RTC multi-channel clock divider.
package rtc_div_pkg;

  localparam int unsigned RTC_CNT_W      = 24;
  localparam int unsigned RTC_SYS_CLK_HZ = 1_000_000;

  // Half-period in system clocks for a target output frequency in Hz.
  function automatic int unsigned half_from_hz(input int unsigned f);
    return RTC_SYS_CLK_HZ / (2 * f);
  endfunction

endpackage

// File: rtl/rtc_div_channel.sv
// One divider slice: half-period counter, output toggle, tick strobe and a
// single pending half-period that is swapped in at the next wrap.
module rtc_div_channel
  import rtc_div_pkg::*;
#(
  parameter int unsigned      CNT_W = RTC_CNT_W,
  parameter logic [CNT_W-1:0] RST_H = CNT_W'(1000)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_half,
  output logic             pend_v,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             wrap;

  assign wrap = en && (half_q != '0) && (cnt_q == half_q - CNT_W'(1));

  always_comb begin
    cnt_d    = cnt_q;
    half_d   = half_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    out_d    = out_q;
    tick_d   = 1'b0;
    if (sync) begin
      // Phase align: everything restarts from zero, pending or fresh value lands now.
      cnt_d = '0;
      out_d = 1'b0;
      if (wr) begin
        half_d   = wr_half;
        pend_d   = wr_half;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        half_d   = pend_q;
        pend_v_d = 1'b0;
      end
    end else begin
      if (wr) begin
        pend_d   = wr_half;
        pend_v_d = 1'b1;
      end
      if (half_q == '0) begin
        cnt_d = '0;
        out_d = 1'b0;
        if (pend_v_q) begin
          half_d   = pend_q;
          pend_v_d = 1'b0;
        end
      end else if (wrap) begin
        // The current half-period always finishes at the old length.
        cnt_d  = '0;
        out_d  = ~out_q;
        tick_d = ~out_q;
        if (pend_v_q) begin
          half_d   = pend_q;
          pend_v_d = 1'b0;
          if (pend_q == '0) begin
            out_d  = 1'b0;
            tick_d = 1'b0;
          end
        end
      end else if (en) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q    <= '0;
      half_q   <= RST_H;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      out_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      out_q    <= out_d;
      tick_q   <= tick_d;
    end
  end

  assign pend_v  = pend_v_q;
  assign clk_out = out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/rtc_multi_clk_div.sv
// NUM_CH independent square-wave dividers with tick strobes and a shared
// one-deep config port. Define RTC_DIV_SYNC_EN to add the sync phase-align input.
module rtc_multi_clk_div
  import rtc_div_pkg::*;
#(
  parameter int unsigned               NUM_CH   = 2,
  parameter int unsigned               CNT_W    = RTC_CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0]   RST_HALF = {24'd2_500_000, 24'd1000},
  localparam int unsigned              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
`ifdef RTC_DIV_SYNC_EN
  ,
  input  logic              sync
`endif
);

  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] pend_v;
  logic              sync_int;

`ifdef RTC_DIV_SYNC_EN
  assign sync_int = sync;
`else
  assign sync_int = 1'b0;
`endif

  // Only one update in flight across all channels.
  assign cfg_ready = ~|pend_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Channel numbers with no matching lane are accepted and dropped.
    assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    rtc_div_channel #(
      .CNT_W (CNT_W),
      .RST_H (RST_HALF[i*CNT_W +: CNT_W])
    ) u_ch (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .en        (en),
      .sync      (sync_int),
      .wr        (wr[i]),
      .wr_half   (cfg_half),
      .pend_v    (pend_v[i]),
      .clk_out   (clk_out[i]),
      .tick      (tick[i])
    );
  end

endmodule
